// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequential signed multiplier using radix-4 (modified Booth) recoding,
// two multiplier bits per cycle, fixed WIDTH/2-cycle run.
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] Mplr,
  input  logic [WIDTH-1:0] Mcnd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mcnd, mq, nmq;
  logic qm1, last;
  logic [2:0] trip;
  logic [AW-1:0] acc, m1, m2, pp, sum, nacc;
  assign last = state == RUN && cnt == LAST;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clock or negedge clear)
    if (!clear) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) :
          state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  // Booth digit from {b(2i+1), b(2i), b(2i-1)}; 2M needs AW bits so MIN*MIN is exact
  always_comb begin
    trip = {mq[1:0], qm1};
    m1   = {{2{mcnd[WIDTH-1]}}, mcnd};
    m2   = m1 << 1;
    pp   = (trip == 3'b001 || trip == 3'b010) ? m1 :
           trip == 3'b011 ? m2 :
           trip == 3'b100 ? -m2 :
           (trip == 3'b101 || trip == 3'b110) ? -m1 : '0;
    sum  = acc + pp;
    nacc = {{2{sum[AW-1]}}, sum[AW-1:2]};
    nmq  = {sum[1:0], mq[WIDTH-1:2]};
  end
  always_ff @(posedge clock or negedge clear)
    if (!clear) begin
      cnt  <= '0;
      mcnd <= '0;
      mq   <= '0;
      qm1  <= 1'b0;
      acc  <= '0;
      HI   <= '0;
      LO   <= '0;
    end else if (state == IDLE && start) begin
      cnt  <= '0;
      mcnd <= Mcnd;
      mq   <= Mplr;
      qm1  <= 1'b0;
      acc  <= '0;
    end else if (state == RUN) begin
      cnt <= last ? '0 : cnt + 1'b1;
      acc <= nacc;
      mq  <= nmq;
      qm1 <= mq[1];
      if (last) begin
        HI <= nacc[WIDTH-1:0];
        LO <= nmq;
      end
    end
endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand width; SHALL be even and >= 4.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: clear  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request pulse or level; sampled only in IDLE.
REQ-005 Port: Mplr  input  WIDTH  multiplier, two's complement; sampled on the accepting edge.
REQ-006 Port: Mcnd  input  WIDTH  multiplicand, two's complement; sampled on the accepting edge.
REQ-007 Port: busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-008 Port: done  output  1  one-cycle completion strobe.
REQ-009 Port: HI  output  WIDTH  upper half of the signed 2*WIDTH product.
REQ-010 Port: LO  output  WIDTH  lower half of the signed 2*WIDTH product.

Function
REQ-011 Block SHALL compute the signed product Mplr*Mcnd sequentially, using radix-4 (modified Booth) recoding of two multiplier bits per cycle.
REQ-012 FSM states SHALL be IDLE, RUN and DONE, with no other reachable states.
REQ-013 IDLE to RUN SHALL occur on a rising edge with start=1; on that same edge Mplr and Mcnd SHALL be captured into internal registers.
REQ-014 In RUN, an iteration counter SHALL start at 0 and increment once per cycle.
REQ-015 The RUN to DONE transition SHALL occur on the edge that completes iteration WIDTH/2-1, so RUN lasts exactly WIDTH/2 cycles (16 when WIDTH=32).
REQ-016 Each RUN cycle SHALL recode the multiplier triplet {b(2i+1), b(2i), b(2i-1)}, with b(-1)=0, into one of 0, +M, +2M, -M, -2M.
REQ-017 Each RUN cycle SHALL add the recoded value to a sign-extended accumulator of at least WIDTH+2 bits, then arithmetic-shift the accumulator:multiplier pair right by 2.
REQ-018 -M and -2M SHALL be formed as the two's complement of M and 2M at accumulator width.
REQ-019 The product SHALL be exact for all operand pairs, including MIN*MIN, MIN*-1 and x*0.
REQ-020 HI and LO SHALL load the final product on the RUN to DONE edge.
REQ-021 HI and LO SHALL hold that value until the next RUN to DONE edge; they SHALL NOT show intermediate values.
REQ-022 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL always go to IDLE on the next edge.
REQ-023 Latency SHALL be fixed: done is high during the cycle WIDTH/2+1 edges after the accepting edge, independent of operand values (no early termination).
REQ-024 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-025 A new start SHALL be accepted only in IDLE, so back-to-back operations start no sooner than one cycle after done.
REQ-026 start, Mplr and Mcnd SHALL be ignored while busy=1; a start held high through DONE SHALL be accepted on the first IDLE edge.
REQ-027 Changes on Mplr or Mcnd after the accepting edge SHALL NOT affect the result.
REQ-028 The block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-029 clear=0 SHALL immediately, without waiting for a clock edge, force state=IDLE and counter=0.
REQ-030 clear=0 SHALL immediately force busy=0, done=0, HI=0, LO=0 and all internal operand and accumulator registers to 0.
REQ-031 clear asserted mid-RUN SHALL abort the operation: no done pulse and HI/LO=0.
REQ-032 After clear deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-033 Mplr=32'hFFFFFFFF, Mcnd=0, start one cycle -> done after 17 edges; HI=32'h00000000, LO=32'h00000000.
REQ-034 Mplr=32'h0000FF00, Mcnd=32'h000FFF0F -> HI=32'h0000000F, LO=32'hEF0FF100.
REQ-035 Mplr=32'hFFFFFFFF, Mcnd=32'h000FFF0F -> HI=32'hFFFFFFFF, LO=32'hFFF000F1.
REQ-036 Mplr=Mcnd=32'h80000000 -> HI=32'h40000000, LO=0; Mplr=32'h80000000, Mcnd=32'hFFFFFFFF -> HI=0, LO=32'h80000000.
REQ-037 start pulsed again at RUN cycle 5 with different operands -> ignored; single done with the first product; busy high for exactly 17 cycles.
REQ-038 clear=0 asserted asynchronously at RUN cycle 8 -> busy, done, HI and LO read 0 before the next edge; no done pulse follows; a subsequent operation completes correctly.
